// File: rtl/mux_scan_nx1.sv
// Registered N:1 display multiplexer with a built-in channel scan sequencer.
// Optional anti-ghosting blank cycle on channel change: define MUX_SCAN_BLANKING_EN.
module mux_scan_nx1 #(
    parameter  int ANCHO    = 4,
    parameter  int CANALES  = 4,
    parameter  int DIV      = 50000,
    localparam int SELW     = $clog2(CANALES)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       Modo,
    input  logic                       Habilitar,
    input  logic [SELW-1:0]            Seleccion,
    input  logic [CANALES*ANCHO-1:0]   D,
    output logic [ANCHO-1:0]           Y,
    output logic [SELW-1:0]            Canal,
    output logic [CANALES-1:0]         Anodo,
    output logic                       Tick
);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0]      r_presc;
    logic [SELW-1:0]    r_canal;
    logic [ANCHO-1:0]   r_y;
    logic [CANALES-1:0] r_anodo;
    logic               r_tick;

    logic [ANCHO-1:0]   w_ch [CANALES];
    logic [SELW-1:0]    w_next;
    logic [CANALES-1:0] w_strobe;
    logic [CANALES-1:0] w_anodo_nx;
    logic               w_wrap;

    for (genvar k = 0; k < CANALES; k++) begin : g_ch
        assign w_ch[k] = D[k*ANCHO +: ANCHO];
    end

    assign w_wrap = Habilitar && Modo && (r_presc == PW'(DIV - 1));

    // Next channel: manual select (out-of-range holds) or auto advance on wrap.
    always_comb begin
        w_next = r_canal;
        if (!Modo) begin
            if (int'(Seleccion) < CANALES)
                w_next = Seleccion;
        end else if (w_wrap) begin
            w_next = (r_canal == SELW'(CANALES - 1)) ? '0 : r_canal + SELW'(1);
        end
    end

    assign w_strobe = ~(CANALES'(1) << w_next);

`ifdef MUX_SCAN_BLANKING_EN
    // Blank all digits for the one cycle in which the channel changes.
    assign w_anodo_nx = (w_next != r_canal) ? '1 : w_strobe;
`else
    assign w_anodo_nx = w_strobe;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_canal <= '0;
            r_y     <= '0;
            r_anodo <= '1;
            r_tick  <= 1'b0;
        end else if (!Habilitar) begin
            r_presc <= '0;
            r_anodo <= '1;
            r_tick  <= 1'b0;
        end else begin
            if (w_wrap || !Modo)
                r_presc <= '0;
            else
                r_presc <= r_presc + PW'(1);
            r_tick  <= w_wrap;
            r_canal <= w_next;
            r_y     <= w_ch[w_next];
            r_anodo <= w_anodo_nx;
        end
    end

    assign Y     = r_y;
    assign Canal = r_canal;
    assign Anodo = r_anodo;
    assign Tick  = r_tick;
endmodule
